// File: rtl/fir_coeff_loader_if.sv
// Host-side bus of the FIR coefficient loader.
//  wr_en/wr_addr/wr_data/auto_inc : shadow-bank write port
//  rd_addr/rd_data                : registered shadow readback
//  commit/sync                    : commit request and data-path boundary
//  err_clr/err                    : sticky error flags and their clear
//  busy/commit_done               : status
//  gain_sum/gain_valid            : DC gain of the active bank
// Handshake: wr_en and commit are single-cycle strobes that the loader
// accepts only in a cycle where busy is low; a strobe seen while busy is
// high is dropped (a dropped write also raises err[1]). There is no
// back-pressure beyond busy, and nothing is queued.
interface fir_coeff_loader_if #(
  parameter int CW = 16
);
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [CW-1:0] wr_data;
  logic          auto_inc;
  logic          commit;
  logic          sync;
  logic [3:0]    rd_addr;
  logic [CW-1:0] rd_data;
  logic          err_clr;
  logic [2:0]    err;
  logic          busy;
  logic          commit_done;
  logic [19:0]   gain_sum;
  logic          gain_valid;

  modport master (
    output wr_en, wr_addr, wr_data, auto_inc, commit, sync, rd_addr, err_clr,
    input  rd_data, err, busy, commit_done, gain_sum, gain_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, auto_inc, commit, sync, rd_addr, err_clr,
    output rd_data, err, busy, commit_done, gain_sum, gain_valid
  );
endinterface

// File: rtl/fir_coeff_loader.sv
// Writer side of a 12-tap FIR coefficient interface.
// The host fills a shadow bank; a commit copies the whole shadow bank into
// the active bank on the next sync boundary (or after a timeout), so the FIR
// never sees a half-updated set. After the copy the DC gain (sum of the
// active taps) is accumulated one tap per cycle.
// Ports:
//  clk, rst          clock, asynchronous active-high reset
//  bus               host bus (write, readback, commit, sync, status, gain)
//  coeff_0..coeff_11 active bank, to the FIR
//  state_dbg         current FSM state (IDLE=0, WAIT_SYNC=1, SUM=2)
//  ptr_dbg           current auto-increment write pointer
module fir_coeff_loader #(
  parameter int          NTAPS        = 12,  // coeff_n port list is fixed at 12
  parameter int          CW           = 16,
  parameter logic [15:0] RESET_TAP0   = 16'h2000,
  parameter int          SYNC_TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  fir_coeff_loader_if.slave bus,
  output logic [CW-1:0]    coeff_0,
  output logic [CW-1:0]    coeff_1,
  output logic [CW-1:0]    coeff_2,
  output logic [CW-1:0]    coeff_3,
  output logic [CW-1:0]    coeff_4,
  output logic [CW-1:0]    coeff_5,
  output logic [CW-1:0]    coeff_6,
  output logic [CW-1:0]    coeff_7,
  output logic [CW-1:0]    coeff_8,
  output logic [CW-1:0]    coeff_9,
  output logic [CW-1:0]    coeff_10,
  output logic [CW-1:0]    coeff_11,
  output logic [1:0]       state_dbg,
  output logic [3:0]       ptr_dbg
);
  localparam int          GW        = 20;
  localparam int          TW        = $clog2(SYNC_TIMEOUT + 1);
  localparam int          SW        = $clog2(NTAPS + 1);
  localparam logic [3:0]  NTAPS_A   = 4'(NTAPS);
  localparam logic [SW-1:0] NTAPS_S = SW'(NTAPS);
  localparam logic [TW-1:0] TMO     = TW'(SYNC_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    SUM       = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   shadow [NTAPS];
  logic [CW-1:0]   active [NTAPS];
  logic [3:0]      ptr;
  logic [TW-1:0]   timer;
  logic [SW-1:0]   sum_idx;
  logic [GW-1:0]   acc;
  logic [GW-1:0]   gain_sum_q;
  logic            gain_valid_q;
  logic            commit_done_q;
  logic [CW-1:0]   rd_data_q;
  logic [2:0]      err_q;

  // Decoded controls for this cycle
  logic            commit_go;
  logic            copy_fire;
  logic            sum_last;
  logic            wr_ok;
  logic [3:0]      wr_idx;
  logic [2:0]      err_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    commit_go = 1'b0;
    copy_fire = 1'b0;
    sum_last  = 1'b0;
    wr_ok     = 1'b0;
    wr_idx    = bus.auto_inc ? ptr : bus.wr_addr;
    err_set   = 3'b000;
    case (state)
      IDLE: begin
        if (bus.wr_en) begin
          if (wr_idx < NTAPS_A) wr_ok = 1'b1;
          else                  err_set[0] = 1'b1;
        end
        // A sync in this same cycle is not looked at: WAIT_SYNC starts
        // next cycle and waits for the following boundary.
        if (bus.commit) begin
          commit_go = 1'b1;
          state_nxt = WAIT_SYNC;
        end
      end
      WAIT_SYNC: begin
        if (bus.wr_en) err_set[1] = 1'b1;
        if (bus.sync || (timer == TMO)) begin
          copy_fire = 1'b1;
          state_nxt = SUM;
          if (!bus.sync) err_set[2] = 1'b1;
        end
      end
      SUM: begin
        if (bus.wr_en) err_set[1] = 1'b1;
        // sum_idx 0..NTAPS-1 add one tap each; the extra cycle publishes.
        if (sum_idx == NTAPS_S) begin
          sum_last  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        shadow[i] <= (i == 0) ? RESET_TAP0 : '0;
        active[i] <= (i == 0) ? RESET_TAP0 : '0;
      end
      ptr           <= '0;
      timer         <= '0;
      sum_idx       <= '0;
      acc           <= '0;
      gain_sum_q    <= {{(GW-CW){RESET_TAP0[CW-1]}}, RESET_TAP0};
      gain_valid_q  <= 1'b1;
      commit_done_q <= 1'b0;
      rd_data_q     <= '0;
      err_q         <= '0;
    end else begin
      if (wr_ok) shadow[wr_idx] <= bus.wr_data;

      if (copy_fire)
        ptr <= '0;
      else if (wr_ok && bus.auto_inc)
        ptr <= (ptr == NTAPS_A - 4'd1) ? 4'd0 : ptr + 4'd1;

      // Readback sees the pre-write value when a write hits the same tap.
      rd_data_q <= (bus.rd_addr < NTAPS_A) ? shadow[bus.rd_addr] : '0;

      if (commit_go)               timer <= '0;
      else if (state == WAIT_SYNC) timer <= timer + TW'(1);

      if (commit_go) gain_valid_q <= 1'b0;
      else if (sum_last) gain_valid_q <= 1'b1;

      if (copy_fire) begin
        for (int i = 0; i < NTAPS; i++) active[i] <= shadow[i];
        acc     <= '0;
        sum_idx <= '0;
      end else if (state == SUM && !sum_last) begin
        acc     <= acc + {{(GW-CW){active[sum_idx][CW-1]}}, active[sum_idx]};
        sum_idx <= sum_idx + SW'(1);
      end

      if (sum_last) gain_sum_q <= acc;

      commit_done_q <= copy_fire;

      // A new error in the same cycle as err_clr stays set.
      err_q <= (bus.err_clr ? 3'b000 : err_q) | err_set;
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.err         = err_q;
  assign bus.busy        = (state != IDLE);
  assign bus.commit_done = commit_done_q;
  assign bus.gain_sum    = gain_sum_q;
  assign bus.gain_valid  = gain_valid_q;

  assign coeff_0  = active[0];
  assign coeff_1  = active[1];
  assign coeff_2  = active[2];
  assign coeff_3  = active[3];
  assign coeff_4  = active[4];
  assign coeff_5  = active[5];
  assign coeff_6  = active[6];
  assign coeff_7  = active[7];
  assign coeff_8  = active[8];
  assign coeff_9  = active[9];
  assign coeff_10 = active[10];
  assign coeff_11 = active[11];

  assign state_dbg = state;
  assign ptr_dbg   = ptr;
endmodule

// File: tb/tb_fir_coeff_loader.sv
module tb_fir_coeff_loader;
  localparam int NT  = 12;
  localparam int TMO = 1023;

  logic clk;
  logic rst;
  wire logic [15:0] coeff [NT];
  wire logic [1:0]  state_dbg;
  wire logic [3:0]  ptr_dbg;

  fir_coeff_loader_if #(.CW(16)) ifc ();

  fir_coeff_loader dut (
    .clk(clk), .rst(rst), .bus(ifc),
    .coeff_0(coeff[0]), .coeff_1(coeff[1]), .coeff_2(coeff[2]),
    .coeff_3(coeff[3]), .coeff_4(coeff[4]), .coeff_5(coeff[5]),
    .coeff_6(coeff[6]), .coeff_7(coeff[7]), .coeff_8(coeff[8]),
    .coeff_9(coeff[9]), .coeff_10(coeff[10]), .coeff_11(coeff[11]),
    .state_dbg(state_dbg), .ptr_dbg(ptr_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model and scoreboard ----------------
  logic [15:0] model_shadow [NT];
  logic [15:0] model_active [NT];
  int          model_ptr;
  logic [15:0] exp_q [$];       // expected readback values
  logic [19:0] gain_exp_q [$];  // expected gain per commit
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      model_shadow[i] = (i == 0) ? 16'h2000 : 16'h0000;
      model_active[i] = model_shadow[i];
    end
    model_ptr = 0;
  endtask

  function automatic logic [19:0] model_gain();
    int s = 0;
    for (int i = 0; i < NT; i++) s += int'($signed(model_shadow[i]));
    return 20'(s);
  endfunction

  // ---------------- driver tasks (all start/end at posedge+1) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [15:0] data, input bit ai);
    int idx;
    ifc.wr_en = 1'b1; ifc.wr_addr = 4'(addr); ifc.wr_data = data; ifc.auto_inc = ai;
    tick();
    ifc.wr_en = 1'b0; ifc.auto_inc = 1'b0;
    idx = ai ? model_ptr : addr;
    if (idx < NT) begin
      model_shadow[idx] = data;
      if (ai) model_ptr = (model_ptr == NT - 1) ? 0 : model_ptr + 1;
    end
  endtask

  task automatic rd(input int addr);
    ifc.rd_addr = 4'(addr);
    exp_q.push_back((addr < NT) ? model_shadow[addr] : 16'h0000);
    tick();
    check($sformatf("rd_data[%0d]", addr), 32'(ifc.rd_data), 32'(exp_q.pop_front()));
  endtask

  task automatic commit(input bit with_sync);
    ifc.commit = 1'b1; ifc.sync = with_sync;
    gain_exp_q.push_back(model_gain());
    tick();
    ifc.commit = 1'b0; ifc.sync = 1'b0;
    check("busy_after_commit", 32'(ifc.busy), 32'd1);
    check("gain_valid_low", 32'(ifc.gain_valid), 32'd0);
  endtask

  task automatic check_coeffs(input string tag);
    for (int i = 0; i < NT; i++)
      check($sformatf("%s_coeff%0d", tag, i), 32'(coeff[i]), 32'(model_active[i]));
  endtask

  // Waits for commit_done; optionally pulses sync in the first cycle.
  task automatic wait_done(input bit pulse_sync, input int budget, output int n);
    n = 0;
    if (pulse_sync) ifc.sync = 1'b1;
    while (n < budget && ifc.commit_done !== 1'b1) begin
      tick();
      ifc.sync = 1'b0;
      n++;
    end
    check("commit_done_seen", 32'(ifc.commit_done), 32'd1);
    for (int i = 0; i < NT; i++) model_active[i] = model_shadow[i];
    check_coeffs("copy");
    check("ptr_zero_after_copy", 32'(ptr_dbg), 32'd0);
    model_ptr = 0;
  endtask

  task automatic wait_gain(input int budget);
    int n = 0;
    while (n < budget && !(ifc.gain_valid === 1'b1 && ifc.busy === 1'b0)) begin
      tick();
      n++;
    end
    check("gain_ready", 32'(ifc.gain_valid && !ifc.busy), 32'd1);
    check("gain_q_nonempty", 32'(gain_exp_q.size() > 0), 32'd1);
    if (gain_exp_q.size() > 0)
      check("gain_sum", 32'(ifc.gain_sum), 32'(gain_exp_q.pop_front()));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    logic [15:0] v;
    ifc.wr_en = 0; ifc.wr_addr = 0; ifc.wr_data = 0; ifc.auto_inc = 0;
    ifc.commit = 0; ifc.sync = 0; ifc.rd_addr = 0; ifc.err_clr = 0;
    rst = 1'b0;
    model_reset();
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;

    // 1: reset state
    check_coeffs("reset");
    check("reset_gain_sum", 32'(ifc.gain_sum), 32'h02000);
    check("reset_gain_valid", 32'(ifc.gain_valid), 32'd1);
    check("reset_busy", 32'(ifc.busy), 32'd0);
    check("reset_err", 32'(ifc.err), 32'd0);
    check("reset_rd_data", 32'(ifc.rd_data), 32'd0);
    check("reset_commit_done", 32'(ifc.commit_done), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);

    // 2: auto-increment fill, commit with sync 5 cycles later
    for (int i = 0; i < NT; i++) wr(0, 16'(i + 1), 1'b1);
    check("ptr_wrapped", 32'(ptr_dbg), 32'd0);
    rd(11);
    rd(0);
    commit(1'b0);
    repeat (3) tick();
    check("pre_sync_coeff0", 32'(coeff[0]), 32'h2000);
    check("wait_state", 32'(state_dbg), 32'd1);
    ifc.sync = 1'b1;
    tick();
    ifc.sync = 1'b0;
    for (int i = 0; i < NT; i++) model_active[i] = model_shadow[i];
    check_coeffs("sync_copy");
    check("commit_done_pulse", 32'(ifc.commit_done), 32'd1);
    check("sum_state", 32'(state_dbg), 32'd2);
    tick();
    check("commit_done_once", 32'(ifc.commit_done), 32'd0);
    ifc.commit = 1'b1;  // commit during SUM must be dropped
    tick();
    ifc.commit = 1'b0;
    repeat (10) tick();
    check("sum_not_done_c12", 32'(ifc.gain_valid), 32'd0);
    check("busy_c12", 32'(ifc.busy), 32'd1);
    tick();
    check("gain_valid_c13", 32'(ifc.gain_valid), 32'd1);
    check("busy_c13", 32'(ifc.busy), 32'd0);
    check("gain_sum_78", 32'(ifc.gain_sum), 32'(gain_exp_q.pop_front()));
    check("gain_sum_78_const", 32'(ifc.gain_sum), 32'd78);
    repeat (2) tick();
    check("commit_not_queued", 32'(ifc.busy), 32'd0);

    // same-cycle write+read returns old value
    ifc.rd_addr = 4'd2;
    exp_q.push_back(model_shadow[2]);
    ifc.wr_en = 1'b1; ifc.wr_addr = 4'd2; ifc.wr_data = 16'h1234;
    tick();
    ifc.wr_en = 1'b0;
    model_shadow[2] = 16'h1234;
    check("rd_old_value", 32'(ifc.rd_data), 32'(exp_q.pop_front()));
    rd(2);

    // 3: bad address, write while busy, err_clr
    wr(13, 16'hdead, 1'b0);
    check("err_bad_addr", 32'(ifc.err), 32'b001);
    for (int i = 0; i < NT; i++) rd(i);
    rd(13);
    ifc.err_clr = 1'b1; tick(); ifc.err_clr = 1'b0;
    check("err_cleared", 32'(ifc.err), 32'd0);
    ifc.err_clr = 1'b1; ifc.wr_en = 1'b1; ifc.wr_addr = 4'd14;
    tick();
    ifc.err_clr = 1'b0; ifc.wr_en = 1'b0;
    check("err_set_wins", 32'(ifc.err), 32'b001);
    ifc.err_clr = 1'b1; tick(); ifc.err_clr = 1'b0;
    commit(1'b0);
    ifc.wr_en = 1'b1; ifc.wr_addr = 4'd3; ifc.wr_data = 16'h7777;
    tick();
    ifc.wr_en = 1'b0;
    check("err_wr_busy", 32'(ifc.err), 32'b010);
    ifc.err_clr = 1'b1; tick(); ifc.err_clr = 1'b0;
    check("err_clr_busy", 32'(ifc.err), 32'd0);
    wait_done(1'b1, 20, n);
    wait_gain(30);
    rd(3);

    // 4a: sync held low -> forced copy after timeout
    for (int i = 0; i < 5; i++) wr(0, 16'(100 * i - 300), 1'b1);
    for (int i = 5; i < NT; i++) wr(i, 16'($urandom_range(0, 16'hffff)), 1'b0);
    check("ptr_before_timeout", 32'(ptr_dbg), 32'd5);
    commit(1'b0);
    wait_done(1'b0, 2000, n);
    check("timeout_latency", 32'(n), 32'(TMO + 1));
    check("err_timeout", 32'(ifc.err), 32'b100);
    wait_gain(30);
    ifc.err_clr = 1'b1; tick(); ifc.err_clr = 1'b0;

    // 4b: sync in the commit cycle is not the boundary
    for (int i = 0; i < NT; i++) wr(i, 16'(3 * i + 1), 1'b0);
    commit(1'b1);
    repeat (3) tick();
    check("sync_same_cycle_wait", 32'(state_dbg), 32'd1);
    check("sync_same_cycle_coeff", 32'(coeff[0]), 32'(model_active[0]));
    wait_done(1'b1, 10, n);
    check("sync_next_latency", 32'(n), 32'd1);
    check("no_timeout_err", 32'(ifc.err), 32'd0);
    wait_gain(30);

    // 5: most negative taps
    for (int i = 0; i < NT; i++) wr(0, 16'h8000, 1'b1);
    commit(1'b0);
    wait_done(1'b1, 10, n);
    wait_gain(30);
    check("gain_neg_const", 32'(ifc.gain_sum), 32'h0A0000);

    // 6: reset during SUM
    for (int i = 0; i < NT; i++) wr(i, 16'($urandom_range(0, 16'hffff)), 1'b0);
    commit(1'b0);
    ifc.sync = 1'b1; tick(); ifc.sync = 1'b0;
    repeat (4) tick();
    check("in_sum_before_reset", 32'(state_dbg), 32'd2);
    #2 rst = 1'b1;
    #1;
    model_reset();
    gain_exp_q.delete();
    check_coeffs("midsum_reset");
    check("midsum_gain_sum", 32'(ifc.gain_sum), 32'h02000);
    check("midsum_gain_valid", 32'(ifc.gain_valid), 32'd1);
    check("midsum_busy", 32'(ifc.busy), 32'd0);
    check("midsum_ptr", 32'(ptr_dbg), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    rd(0);
    rd(7);
    for (int i = 0; i < NT; i++) begin
      v = 16'($urandom_range(0, 16'hffff));
      wr(0, v, 1'b1);
    end
    commit(1'b0);
    repeat ($urandom_range(1, 6)) tick();
    wait_done(1'b1, 10, n);
    wait_gain(30);
    check("final_err", 32'(ifc.err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
